// File: rtl/buffer_tile_ctrl_pkg.sv
// Shared types and constants for the buffer tile sequencer and its output skid FIFO.
package buffer_tile_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tile_state_e;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/buffer_tile_skid.sv
// Two-entry output skid FIFO absorbing the buffer's 1-cycle read latency under backpressure.
module buffer_tile_skid
  import buffer_tile_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 129
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [SKID_CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic             wr_idx;
  logic             rd_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= ~wr_idx;
      end
      if (pop) begin
        rd_idx <= ~rd_idx;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_idx];

  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push && !pop && (cnt == SKID_CNT_W'(SKID_DEPTH))))
    else $error("buffer_tile_skid: push into full FIFO");

endmodule

// File: rtl/buffer_tile_ctrl.sv
// Tile sequencer: loads rows into the accelerator buffer, then drains them in order to the array feeder.
module buffer_tile_ctrl
  import buffer_tile_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH      = 20,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  tile_rows,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  buf_wr_en,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [DATA_WIDTH-1:0] buf_wr_data,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rd_data
);

  localparam int unsigned OCC_W = SKID_CNT_W + 1;

  tile_state_e           state, state_nxt;
  logic [CNT_WIDTH-1:0]  rows;
  logic [CNT_WIDTH-1:0]  issued;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  inflight;
  logic                  inflight_last;
  logic                  cfg_err_q;

  logic                  start_ok;
  logic                  in_hs;
  logic                  wr_last;
  logic                  pop;
  logic                  issue;
  logic                  issue_last;
  logic [SKID_CNT_W-1:0] fifo_cnt;
  logic [DATA_WIDTH:0]   head;
  logic [OCC_W-1:0]      occ;
  logic [OCC_W-1:0]      room;

  assign start_ok = (tile_rows != '0) && (tile_rows <= CNT_WIDTH'(DEPTH));
  assign in_ready = (state == ST_LOAD);
  assign in_hs    = in_valid && in_ready;
  assign wr_last  = (CNT_WIDTH'(wr_ptr) == rows - 1'b1);

  assign buf_wr_en   = in_hs;
  assign buf_wr_addr = wr_ptr;
  assign buf_wr_data = in_data;
  assign buf_rd_addr = rd_ptr;

  assign out_valid = (fifo_cnt != '0);
  assign out_data  = head[DATA_WIDTH-1:0];
  assign out_last  = head[DATA_WIDTH];
  assign pop       = out_valid && out_ready;

  // Reads in flight count against FIFO space; a same-cycle pop frees one slot.
  assign occ        = {1'b0, fifo_cnt} + OCC_W'(inflight);
  assign room       = OCC_W'(SKID_DEPTH) + OCC_W'(pop);
  assign issue      = (state == ST_DRAIN) && (issued < rows) && (occ < room);
  assign issue_last = (issued == rows - 1'b1);

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign cfg_err = cfg_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start && start_ok)  state_nxt = ST_LOAD;
      ST_LOAD:  if (in_hs && wr_last)   state_nxt = ST_DRAIN;
      ST_DRAIN: if (pop && out_last)    state_nxt = ST_DONE;
      ST_DONE:                          state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows          <= '0;
      issued        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      cfg_err_q     <= (state == ST_IDLE) && start && !start_ok;
      inflight      <= issue;
      inflight_last <= issue && issue_last;
      case (state)
        ST_IDLE: begin
          if (start && start_ok) begin
            rows   <= tile_rows;
            wr_ptr <= '0;
          end
        end
        ST_LOAD: begin
          if (in_hs) begin
            if (wr_last) begin
              rd_ptr <= '0;
              issued <= '0;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (issue) begin
            rd_ptr <= rd_ptr + 1'b1;
            issued <= issued + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  buffer_tile_skid #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data ({inflight_last, buf_rd_data}),
    .pop       (pop),
    .head      (head),
    .cnt       (fifo_cnt)
  );

endmodule
